exc_ctrl: RTL

- Exception and interrupt arbiter between the memory stage and the CP0 register file.
- Each cycle it takes the memory-stage instruction's exception flags and the CP0 Status, Cause and EPC values, with any write-back-stage CP0 write forwarded in.
- From these it selects one exception type and drives the `excepttype_o`, `exc_pc_o` and `exc_bd_o` CP0 capture signals.
- It also sequences the pipeline flush and the PC redirect to the exception vector or to EPC.

---
 rtl/exc_ctrl_pkg.sv | 38 +++
 rtl/exc_ctrl_if.sv | 37 +++
 rtl/exc_ctrl_cp0_fwd.sv | 36 +++
 rtl/exc_ctrl.sv | 135 +++++++++++++
 4 files changed

// File: rtl/exc_ctrl_pkg.sv
// Shared constants for the exception controller: CP0 register addresses,
// exception codes, exception flag bit positions and the FSM state type.
package exc_ctrl_pkg;

    // CP0 register addresses
    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;
    localparam logic [4:0] CP0_PRID    = 5'd15;
    localparam logic [4:0] CP0_CONFIG  = 5'd16;

    // Exception codes driven on excepttype_o
    localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
    localparam logic [31:0] EXC_INT     = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
    localparam logic [31:0] EXC_RI      = 32'h0000_000a;
    localparam logic [31:0] EXC_OV      = 32'h0000_000c;
    localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

    // Bit positions inside exc_flags_i
    localparam int unsigned FLAG_SYSCALL = 0;
    localparam int unsigned FLAG_RI      = 1;
    localparam int unsigned FLAG_TRAP    = 2;
    localparam int unsigned FLAG_OV      = 3;
    localparam int unsigned FLAG_ERET    = 4;

    // Cause bits that software may write: IP1..IP0 (9:8), IV (23), WP (22)
    localparam logic [31:0] CAUSE_WR_MASK = 32'h00C0_0300;

    typedef enum logic {
        StIdle  = 1'b0,
        StFlush = 1'b1
    } exc_state_e;

endpackage

// File: rtl/exc_ctrl_if.sv
// Memory-stage / CP0 side bundle of the exception controller.
// slave: the controller itself; master: the pipeline/CP0 driving it.
interface exc_ctrl_if;
    import exc_ctrl_pkg::*;

    logic        valid_i;
    logic [31:0] inst_addr_i;
    logic        in_delayslot_i;
    logic [4:0]  exc_flags_i;
    logic [31:0] cp0_status_i;
    logic [31:0] cp0_cause_i;
    logic [31:0] cp0_epc_i;
    logic        wb_cp0_we_i;
    logic [4:0]  wb_cp0_waddr_i;
    logic [31:0] wb_cp0_data_i;

    logic [31:0] excepttype_o;
    logic [31:0] exc_pc_o;
    logic        exc_bd_o;
    logic        flush_o;
    logic [31:0] new_pc_o;

    modport slave (
        input  valid_i, inst_addr_i, in_delayslot_i, exc_flags_i,
        input  cp0_status_i, cp0_cause_i, cp0_epc_i,
        input  wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
        output excepttype_o, exc_pc_o, exc_bd_o, flush_o, new_pc_o
    );

    modport master (
        output valid_i, inst_addr_i, in_delayslot_i, exc_flags_i,
        output cp0_status_i, cp0_cause_i, cp0_epc_i,
        output wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
        input  excepttype_o, exc_pc_o, exc_bd_o, flush_o, new_pc_o
    );

endinterface

// File: rtl/exc_ctrl_cp0_fwd.sv
// CP0 forwarding network: merges an in-flight write-back CP0 write into the
// Status, Cause and EPC values seen by the exception decision (zero latency).
module cp0_fwd
    import exc_ctrl_pkg::*;
(
    input  logic [31:0] i_status,
    input  logic [31:0] i_cause,
    input  logic [31:0] i_epc,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_status,
    output logic [31:0] o_cause,
    output logic [31:0] o_epc
);

    // Select forwarded or architectural value per register
    always_comb begin
        o_status = i_status;
        o_cause  = i_cause;
        o_epc    = i_epc;
        if (i_we) begin
            if (i_waddr == CP0_STATUS) begin
                o_status = i_wdata;
            end
            // Only the software-writable Cause bits are taken from the write
            if (i_waddr == CP0_CAUSE) begin
                o_cause = (i_cause & ~CAUSE_WR_MASK) | (i_wdata & CAUSE_WR_MASK);
            end
            if (i_waddr == CP0_EPC) begin
                o_epc = i_wdata;
            end
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt arbiter between the memory stage and CP0. Picks one
// exception per cycle, drives the CP0 capture signals, and sequences the
// pipeline flush and PC redirect.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic     clk,
    input  logic     rst,
    exc_ctrl_if.slave bus
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    exc_state_e  r_state;
    exc_state_e  w_state_nxt;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_nxt;
    logic [31:0] r_new_pc;
    logic [31:0] w_new_pc_nxt;

    logic [31:0] w_status;
    logic [31:0] w_cause;
    logic [31:0] w_epc;
    logic        w_int_pending;
    logic        w_eligible;
    logic [31:0] w_excepttype;
    logic        w_accept;
    logic [31:0] w_target;
    logic [31:0] w_exc_pc;

    cp0_fwd u_cp0_fwd (
        .i_status (bus.cp0_status_i),
        .i_cause  (bus.cp0_cause_i),
        .i_epc    (bus.cp0_epc_i),
        .i_we     (bus.wb_cp0_we_i),
        .i_waddr  (bus.wb_cp0_waddr_i),
        .i_wdata  (bus.wb_cp0_data_i),
        .o_status (w_status),
        .o_cause  (w_cause),
        .o_epc    (w_epc)
    );

    assign w_int_pending = (|(w_status[15:8] & w_cause[15:8])) & w_status[0] & ~w_status[1];

    // Events in FLUSH belong to instructions being squashed, so only IDLE listens
    assign w_eligible = bus.valid_i & (r_state == StIdle) & rst;

    // Fixed-priority exception selection
    always_comb begin
        w_excepttype = EXC_NONE;
        if (w_eligible) begin
            if (w_int_pending) begin
                w_excepttype = EXC_INT;
            end else if (bus.exc_flags_i[FLAG_SYSCALL]) begin
                w_excepttype = EXC_SYSCALL;
            end else if (bus.exc_flags_i[FLAG_RI]) begin
                w_excepttype = EXC_RI;
            end else if (bus.exc_flags_i[FLAG_TRAP]) begin
                w_excepttype = EXC_TRAP;
            end else if (bus.exc_flags_i[FLAG_OV]) begin
                w_excepttype = EXC_OV;
            end else if (bus.exc_flags_i[FLAG_ERET]) begin
                w_excepttype = EXC_ERET;
            end
        end
    end

    assign w_accept = (w_excepttype != EXC_NONE);
    assign w_target = (w_excepttype == EXC_ERET) ? w_epc : EXC_VECTOR;
    // A delay-slot instruction restarts at its branch
    assign w_exc_pc = bus.in_delayslot_i ? (bus.inst_addr_i - 32'd4) : bus.inst_addr_i;

    assign bus.excepttype_o = w_excepttype;
    assign bus.exc_pc_o     = w_accept ? w_exc_pc : 32'h0;
    assign bus.exc_bd_o     = w_accept & bus.in_delayslot_i;
    assign bus.flush_o      = w_accept | (r_state == StFlush);

    // Redirect target: live in the accept cycle, latched during FLUSH
    always_comb begin
        bus.new_pc_o = 32'h0;
        if (w_accept) begin
            bus.new_pc_o = w_target;
        end else if (r_state == StFlush) begin
            bus.new_pc_o = r_new_pc;
        end
    end

    // Next-state logic for the flush sequencer
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_new_pc_nxt = r_new_pc;
        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_new_pc_nxt = w_target;
                    w_cnt_nxt    = FLUSH_LOAD;
                    // A one-cycle flush is fully covered by the accept cycle
                    if (FLUSH_LOAD != 3'd0) begin
                        w_state_nxt = StFlush;
                    end
                end
            end
            StFlush: begin
                if (r_cnt <= 3'd1) begin
                    w_cnt_nxt   = 3'd0;
                    w_state_nxt = StIdle;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            default: begin
                w_state_nxt = StIdle;
                w_cnt_nxt   = 3'd0;
            end
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= StIdle;
            r_cnt    <= 3'd0;
            r_new_pc <= 32'h0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_new_pc <= w_new_pc_nxt;
        end
    end

endmodule
